mpc_rr_port_arbiter: RTL and testbench
======================================

Name: mpc_rr_port_arbiter

Overview:
Round-robin, packet-granular arbiter that shares the single cache write path between NUM_PORTS input ports of the multi-port cache. It holds each grant until the granted port's last beat is accepted, or until a stall watchdog fires. It publishes the grant both one-hot, for the datapath mux enables, and binary, for the address/tag index logic. It sits between the per-port ingress buffers and the cache write controller.

Parameters:
NUM_PORTS, 8, number of requesting ports; power of two, >=2.
TIMEOUT_CYCLES, 256, consecutive no-accept cycles in BUSY before forced release; >=2.
IDX_W, $clog2(NUM_PORTS), width of the binary grant index; derived, not overridden.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req  in  NUM_PORTS  per-port request; level, one bit per port.
vld  in  NUM_PORTS  per-port beat valid; only the granted bit is observed.
last  in  NUM_PORTS  per-port end-of-packet; qualified by vld and sink_rdy.
sink_rdy  in  1  cache write path can accept a beat this cycle.
gnt_onehot  out  NUM_PORTS  registered one-hot grant; all-zero when idle.
gnt_idx  out  IDX_W  registered binary index of gnt_onehot; 0 when idle.
gnt_vld  out  1  registered; high when exactly one grant bit is set.
beat_acc  out  1  combinational: gnt_vld & vld[gnt_idx] & sink_rdy.
timeout_pulse  out  1  registered one-cycle pulse on forced release.
timeout_port  out  IDX_W  index of the port forcibly released; holds until next timeout.

Behaviour:
- Reset (rst_n low, asynchronous):
  - gnt_onehot=0, gnt_idx=0, gnt_vld=0, timeout_pulse=0, timeout_port=0.
  - Round-robin pointer ptr=0, so port 0 has first priority.
  - Watchdog counter=0; state=IDLE.
- States: IDLE, BUSY.
- IDLE:
  - If |req, pick the first set req bit searching upward from ptr, wrapping N-1 -> 0.
  - Register the winner into gnt_onehot/gnt_idx; gnt_vld=1 next cycle; go to BUSY.
  - Request-to-grant latency is exactly 1 cycle.
- BUSY, with g = current grant:
  - A beat is accepted when beat_acc=1. The watchdog counter clears on every accepted beat and increments otherwise.
  - Release on an accepted beat with last[g]=1.
  - Release on watchdog reaching TIMEOUT_CYCLES-1 with no accept that cycle. Next cycle: timeout_pulse=1, timeout_port=g.
  - On release, ptr <= (g+1) mod NUM_PORTS. Arbitration runs in the same cycle against req, with the search starting at g+1.
  - If any req is set at release, the next grant is registered directly with no idle bubble; state stays BUSY and the watchdog clears.
  - If no req is set at release, grant clears next cycle: gnt_onehot=0, gnt_vld=0, gnt_idx=0; state=IDLE.
  - Port g keeps no priority after release. It wins again only if it is the sole requester or is next in round-robin order.
- req[g] deasserting while in BUSY is ignored; the grant is held until last or timeout.
- vld/last of non-granted ports are ignored.
- last[g] without vld[g] or without sink_rdy does not release.
- Watchdog/last tie: if an accepted last beat coincides with the watchdog reaching its limit, the last wins. No timeout_pulse is generated.
- gnt_idx always equals the onehot-to-binary encoding of gnt_onehot. gnt_onehot never has more than one bit set.
- Reset asserted mid-packet drops the grant immediately (asynchronous); no timeout_pulse is generated.

Test Plan:
- Reset, then req=8'b0000_0100 at cycle 0 -> cycle 1: gnt_onehot=8'h04, gnt_idx=2, gnt_vld=1. Three beats with last on the 3rd and sink_rdy=1 -> grant clears the cycle after the last beat.
- req=8'hFF held; every packet is 2 beats -> grants 0,1,2,...,7,0 back-to-back with no idle cycle; ptr wraps 7->0.
- Port 5 granted, req=8'h21, sink_rdy=0 for all cycles -> after 256 cycles timeout_pulse=1 for one cycle, timeout_port=5; next grant is port 0, not port 5.
- Port 3 granted; req[3] drops mid-packet while req[6]=1 -> grant stays 3 until the last beat is accepted, then next cycle gnt_idx=6.
- Port 1 granted and stalled 255 cycles; on the cycle the watchdog hits its limit, vld=1, last=1, sink_rdy=1 -> normal release, timeout_pulse stays 0.
- rst_n pulsed low while port 4 holds a grant -> all outputs 0 immediately. After release with req=8'h11, grant goes to port 0 (ptr reset).

Source files
------------

// File: rtl/mpc_rr_port_arbiter_if.sv
// Handshake bundle between the per-port ingress buffers, the round-robin arbiter
// and the cache write controller. The arbiter side uses the master modport.
interface mpc_rr_port_arbiter_if #(
  parameter int unsigned NUM_PORTS = 8
);
  localparam int unsigned IDX_W = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] vld;
  logic [NUM_PORTS-1:0] last;
  logic                 sink_rdy;
  logic [NUM_PORTS-1:0] gnt_onehot;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_vld;
  logic                 beat_acc;
  logic                 timeout_pulse;
  logic [IDX_W-1:0]     timeout_port;

  modport master (
    input  req,
    input  vld,
    input  last,
    input  sink_rdy,
    output gnt_onehot,
    output gnt_idx,
    output gnt_vld,
    output beat_acc,
    output timeout_pulse,
    output timeout_port
  );

  modport slave (
    output req,
    output vld,
    output last,
    output sink_rdy,
    input  gnt_onehot,
    input  gnt_idx,
    input  gnt_vld,
    input  beat_acc,
    input  timeout_pulse,
    input  timeout_port
  );
endinterface

// File: rtl/mpc_rr_port_arbiter.sv
// Packet-granular round-robin arbiter for the shared cache write path. Holds a grant
// until the granted port's last beat is accepted or the stall watchdog expires.
module mpc_rr_port_arbiter #(
  parameter int unsigned NUM_PORTS      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic                   clk,
  input logic                   rst_n,
  mpc_rr_port_arbiter_if.master bus
);

  localparam int unsigned IDX_W = $clog2(NUM_PORTS);
  localparam int unsigned CntW  = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] WdogLimit = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e               state_q;
  logic [IDX_W-1:0]     ptr_q;
  logic [CntW-1:0]      wdog_q;
  logic [NUM_PORTS-1:0] gnt_onehot_q;
  logic [IDX_W-1:0]     gnt_idx_q;
  logic                 gnt_vld_q;
  logic                 timeout_pulse_q;
  logic [IDX_W-1:0]     timeout_port_q;

  logic                 beat_acc;
  logic                 last_acc;
  logic                 timeout_hit;
  logic                 release_gnt;
  logic [IDX_W-1:0]     search_base;
  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;
  logic [NUM_PORTS-1:0] pick_onehot;

  assign beat_acc    = gnt_vld_q & bus.vld[gnt_idx_q] & bus.sink_rdy;
  assign last_acc    = beat_acc & bus.last[gnt_idx_q];
  // An accepted last beat beats a watchdog expiry in the same cycle.
  assign timeout_hit = (state_q == StBusy) & ~beat_acc & (wdog_q == WdogLimit);
  assign release_gnt = (state_q == StBusy) & (last_acc | timeout_hit);

  // At release the search starts just past the outgoing grant, which equals the next ptr.
  assign search_base = (state_q == StBusy) ? gnt_idx_q + IDX_W'(1) : ptr_q;

  always_comb begin
    logic [IDX_W-1:0] cand;
    cand       = '0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = search_base + IDX_W'(i);
      if (!pick_found && bus.req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
    pick_onehot = NUM_PORTS'(1) << pick_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      ptr_q           <= '0;
      wdog_q          <= '0;
      gnt_onehot_q    <= '0;
      gnt_idx_q       <= '0;
      gnt_vld_q       <= 1'b0;
      timeout_pulse_q <= 1'b0;
      timeout_port_q  <= '0;
    end else begin
      timeout_pulse_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          wdog_q <= '0;
          if (pick_found) begin
            gnt_onehot_q <= pick_onehot;
            gnt_idx_q    <= pick_idx;
            gnt_vld_q    <= 1'b1;
            state_q      <= StBusy;
          end
        end
        StBusy: begin
          if (release_gnt) begin
            ptr_q  <= gnt_idx_q + IDX_W'(1);
            wdog_q <= '0;
            if (timeout_hit) begin
              timeout_pulse_q <= 1'b1;
              timeout_port_q  <= gnt_idx_q;
            end
            if (pick_found) begin
              gnt_onehot_q <= pick_onehot;
              gnt_idx_q    <= pick_idx;
              gnt_vld_q    <= 1'b1;
            end else begin
              gnt_onehot_q <= '0;
              gnt_idx_q    <= '0;
              gnt_vld_q    <= 1'b0;
              state_q      <= StIdle;
            end
          end else if (beat_acc) begin
            wdog_q <= '0;
          end else begin
            wdog_q <= wdog_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.gnt_onehot    = gnt_onehot_q;
  assign bus.gnt_idx       = gnt_idx_q;
  assign bus.gnt_vld       = gnt_vld_q;
  assign bus.beat_acc      = beat_acc;
  assign bus.timeout_pulse = timeout_pulse_q;
  assign bus.timeout_port  = timeout_port_q;

  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt_onehot_q));
  a_gnt_encoding : assert property (@(posedge clk) disable iff (!rst_n)
    gnt_onehot_q == (gnt_vld_q ? (NUM_PORTS'(1) << gnt_idx_q) : '0));
  a_idle_idx_zero : assert property (@(posedge clk) disable iff (!rst_n)
    !gnt_vld_q |-> (gnt_idx_q == '0));

endmodule

// File: tb/tb_mpc_rr_port_arbiter.sv
// Self-checking bench for mpc_rr_port_arbiter: expected grants and timeout ports are
// queued as stimulus is applied and popped when the arbiter publishes them.
module tb_mpc_rr_port_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   exp_gnt_q[$];
  int   exp_to_q[$];
  int   exp_val;
  int   n;

  mpc_rr_port_arbiter_if #(.NUM_PORTS(8)) bus ();

  mpc_rr_port_arbiter #(
    .NUM_PORTS      (8),
    .TIMEOUT_CYCLES (256)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    bus.req      = '0;
    bus.vld      = '0;
    bus.last     = '0;
    bus.sink_rdy = 1'b0;
    rst_n        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (bus.gnt_onehot !== 8'h00 || bus.gnt_idx !== 3'd0 || bus.gnt_vld !== 1'b0 ||
        bus.timeout_pulse !== 1'b0 || bus.timeout_port !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got oh=%h idx=%0d vld=%b tp=%b tport=%0d, expected all zero",
               bus.gnt_onehot, bus.gnt_idx, bus.gnt_vld, bus.timeout_pulse, bus.timeout_port);
    end
    tick();
    checks++;
    if (bus.gnt_vld !== 1'b0 || bus.gnt_onehot !== 8'h00) begin
      errors++;
      $display("FAIL idle_no_req: got vld=%b oh=%h, expected vld=0 oh=00",
               bus.gnt_vld, bus.gnt_onehot);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    exp_gnt_q.push_back(2);
    bus.req = 8'h04;
    tick();
    exp_val = exp_gnt_q.pop_front();
    checks++;
    if (bus.gnt_vld !== 1'b1 || bus.gnt_idx !== exp_val[2:0] ||
        bus.gnt_onehot !== (8'h01 << exp_val)) begin
      errors++;
      $display("FAIL basic_grant: got vld=%b idx=%0d oh=%h, expected vld=1 idx=%0d",
               bus.gnt_vld, bus.gnt_idx, bus.gnt_onehot, exp_val);
    end
    bus.req      = 8'h00;
    bus.vld      = 8'h04;
    bus.sink_rdy = 1'b1;
    for (int b = 0; b < 3; b++) begin
      bus.last = (b == 2) ? 8'h04 : 8'h00;
      #1;
      checks++;
      if (bus.beat_acc !== 1'b1) begin
        errors++;
        $display("FAIL basic_beat_acc%0d: got %b, expected 1", b, bus.beat_acc);
      end
      tick();
      if (b < 2) begin
        checks++;
        if (bus.gnt_vld !== 1'b1 || bus.gnt_idx !== 3'd2) begin
          errors++;
          $display("FAIL basic_hold%0d: got vld=%b idx=%0d, expected vld=1 idx=2",
                   b, bus.gnt_vld, bus.gnt_idx);
        end
      end
    end
    checks++;
    if (bus.gnt_vld !== 1'b0 || bus.gnt_idx !== 3'd0 || bus.gnt_onehot !== 8'h00) begin
      errors++;
      $display("FAIL basic_release: got vld=%b idx=%0d oh=%h, expected idle",
               bus.gnt_vld, bus.gnt_idx, bus.gnt_onehot);
    end
    // ptr is now 3, so of ports 0 and 2 the search reaches 0 first.
    bus.vld  = 8'h00;
    bus.last = 8'h00;
    bus.req  = 8'h05;
    exp_gnt_q.push_back(0);
    tick();
    exp_val = exp_gnt_q.pop_front();
    checks++;
    if (bus.gnt_vld !== 1'b1 || bus.gnt_idx !== exp_val[2:0]) begin
      errors++;
      $display("FAIL basic_ptr_advance: got vld=%b idx=%0d, expected vld=1 idx=%0d",
               bus.gnt_vld, bus.gnt_idx, exp_val);
    end
  endtask

  task automatic test_qualifiers();
    apply_reset();
    bus.req = 8'h04;
    tick();
    bus.req      = 8'h00;
    bus.vld      = 8'hFB;
    bus.last     = 8'hFF;
    bus.sink_rdy = 1'b1;
    #1;
    checks++;
    if (bus.beat_acc !== 1'b0) begin
      errors++;
      $display("FAIL qual_other_vld: got beat_acc=%b, expected 0", bus.beat_acc);
    end
    tick();
    bus.vld      = 8'h04;
    bus.last     = 8'h04;
    bus.sink_rdy = 1'b0;
    #1;
    checks++;
    if (bus.beat_acc !== 1'b0) begin
      errors++;
      $display("FAIL qual_no_sink: got beat_acc=%b, expected 0", bus.beat_acc);
    end
    tick();
    bus.vld      = 8'h00;
    bus.sink_rdy = 1'b1;
    tick();
    bus.vld  = 8'h04;
    bus.last = 8'hFB;
    #1;
    checks++;
    if (bus.beat_acc !== 1'b1) begin
      errors++;
      $display("FAIL qual_own_beat: got beat_acc=%b, expected 1", bus.beat_acc);
    end
    tick();
    checks++;
    if (bus.gnt_vld !== 1'b1 || bus.gnt_idx !== 3'd2) begin
      errors++;
      $display("FAIL qual_hold: got vld=%b idx=%0d, expected vld=1 idx=2",
               bus.gnt_vld, bus.gnt_idx);
    end
    bus.last = 8'h04;
    tick();
    checks++;
    if (bus.gnt_vld !== 1'b0) begin
      errors++;
      $display("FAIL qual_release: got vld=%b, expected 0", bus.gnt_vld);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 9; i++) exp_gnt_q.push_back(i % 8);
    bus.req      = 8'hFF;
    bus.sink_rdy = 1'b1;
    tick();
    for (int p = 0; p < 9; p++) begin
      exp_val = exp_gnt_q.pop_front();
      checks++;
      if (bus.gnt_vld !== 1'b1 || bus.gnt_idx !== exp_val[2:0] ||
          bus.gnt_onehot !== (8'h01 << exp_val)) begin
        errors++;
        $display("FAIL b2b_grant%0d: got vld=%b idx=%0d oh=%h, expected vld=1 idx=%0d",
                 p, bus.gnt_vld, bus.gnt_idx, bus.gnt_onehot, exp_val);
      end
      bus.vld  = 8'hFF;
      bus.last = 8'h00;
      tick();
      bus.last = 8'hFF;
      tick();
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    bus.req = 8'h20;
    tick();
    exp_to_q.push_back(5);
    exp_gnt_q.push_back(0);
    bus.req      = 8'h21;
    bus.vld      = 8'h20;
    bus.sink_rdy = 1'b0;
    n = 0;
    while (bus.timeout_pulse !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL timeout_latency: got %0d cycles, expected 256", n);
    end
    exp_val = exp_to_q.pop_front();
    checks++;
    if (bus.timeout_port !== exp_val[2:0]) begin
      errors++;
      $display("FAIL timeout_port: got %0d, expected %0d", bus.timeout_port, exp_val);
    end
    exp_val = exp_gnt_q.pop_front();
    checks++;
    if (bus.gnt_vld !== 1'b1 || bus.gnt_idx !== exp_val[2:0]) begin
      errors++;
      $display("FAIL timeout_next_grant: got vld=%b idx=%0d, expected vld=1 idx=%0d",
               bus.gnt_vld, bus.gnt_idx, exp_val);
    end
    tick();
    checks++;
    if (bus.timeout_pulse !== 1'b0 || bus.timeout_port !== 3'd5) begin
      errors++;
      $display("FAIL timeout_pulse_width: got tp=%b tport=%0d, expected tp=0 tport=5",
               bus.timeout_pulse, bus.timeout_port);
    end
  endtask

  task automatic test_req_drop();
    apply_reset();
    checks++;
    if (bus.timeout_port !== 3'd0) begin
      errors++;
      $display("FAIL reset_timeout_port: got %0d, expected 0", bus.timeout_port);
    end
    exp_gnt_q.push_back(3);
    exp_gnt_q.push_back(3);
    exp_gnt_q.push_back(6);
    bus.req = 8'h08;
    tick();
    bus.req      = 8'h40;
    bus.vld      = 8'h08;
    bus.sink_rdy = 1'b1;
    for (int s = 0; s < 3; s++) begin
      exp_val = exp_gnt_q.pop_front();
      checks++;
      if (bus.gnt_vld !== 1'b1 || bus.gnt_idx !== exp_val[2:0]) begin
        errors++;
        $display("FAIL req_drop_step%0d: got vld=%b idx=%0d, expected vld=1 idx=%0d",
                 s, bus.gnt_vld, bus.gnt_idx, exp_val);
      end
      bus.last = (s == 1) ? 8'h08 : 8'h00;
      tick();
    end
  endtask

  task automatic test_tie();
    apply_reset();
    bus.req = 8'h02;
    tick();
    bus.req = 8'h00;
    repeat (255) tick();
    checks++;
    if (bus.gnt_vld !== 1'b1 || bus.gnt_idx !== 3'd1 || bus.timeout_pulse !== 1'b0) begin
      errors++;
      $display("FAIL tie_stalled: got vld=%b idx=%0d tp=%b, expected vld=1 idx=1 tp=0",
               bus.gnt_vld, bus.gnt_idx, bus.timeout_pulse);
    end
    bus.vld      = 8'h02;
    bus.last     = 8'h02;
    bus.sink_rdy = 1'b1;
    tick();
    checks++;
    if (bus.gnt_vld !== 1'b0 || bus.timeout_pulse !== 1'b0) begin
      errors++;
      $display("FAIL tie_last_wins: got vld=%b tp=%b, expected vld=0 tp=0",
               bus.gnt_vld, bus.timeout_pulse);
    end
    tick();
    checks++;
    if (bus.timeout_pulse !== 1'b0) begin
      errors++;
      $display("FAIL tie_no_late_pulse: got tp=%b, expected 0", bus.timeout_pulse);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.req      = 8'h01;
    bus.sink_rdy = 1'b1;
    tick();
    bus.req  = 8'h10;
    bus.vld  = 8'h01;
    bus.last = 8'h01;
    exp_gnt_q.push_back(4);
    tick();
    tick();
    exp_val = exp_gnt_q.pop_front();
    checks++;
    if (bus.gnt_vld !== 1'b1 || bus.gnt_idx !== exp_val[2:0]) begin
      errors++;
      $display("FAIL mid_setup: got vld=%b idx=%0d, expected vld=1 idx=%0d",
               bus.gnt_vld, bus.gnt_idx, exp_val);
    end
    bus.vld  = 8'h10;
    bus.last = 8'h00;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.gnt_onehot !== 8'h00 || bus.gnt_idx !== 3'd0 || bus.gnt_vld !== 1'b0 ||
        bus.timeout_pulse !== 1'b0 || bus.beat_acc !== 1'b0) begin
      errors++;
      $display("FAIL mid_async_reset: got oh=%h idx=%0d vld=%b tp=%b acc=%b, expected zero",
               bus.gnt_onehot, bus.gnt_idx, bus.gnt_vld, bus.timeout_pulse, bus.beat_acc);
    end
    tick();
    rst_n   = 1'b1;
    bus.vld = 8'h00;
    bus.req = 8'h11;
    exp_gnt_q.push_back(0);
    tick();
    exp_val = exp_gnt_q.pop_front();
    checks++;
    if (bus.gnt_vld !== 1'b1 || bus.gnt_idx !== exp_val[2:0] || bus.timeout_pulse !== 1'b0) begin
      errors++;
      $display("FAIL mid_ptr_reset: got vld=%b idx=%0d tp=%b, expected vld=1 idx=%0d tp=0",
               bus.gnt_vld, bus.gnt_idx, bus.timeout_pulse, exp_val);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus.req      = '0;
    bus.vld      = '0;
    bus.last     = '0;
    bus.sink_rdy = 1'b0;
    test_reset();
    test_basic();
    test_qualifiers();
    test_back_to_back();
    test_timeout();
    test_req_drop();
    test_tie();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL sim_timeout: got no completion, expected finish before 1ms");
    $fatal(1);
  end

endmodule
